// File: rtl/ifft_tx_pkg.sv
// Shared types, defaults and helpers for the IFFT sink-side frame transmitter.
package ifft_tx_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_PTS_W  = 11;

    typedef enum logic {IDLE, STREAM} tx_state_e;

    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_MISSING_SOP = 2'b01;
    localparam logic [1:0] ERR_MISSING_EOP = 2'b10;
    localparam logic [1:0] ERR_UNEXP_EOP   = 2'b11;

    // Legal frame lengths are powers of two from 8 up to max_pts.
    function automatic logic is_legal_pts(input int unsigned pts, input int unsigned max_pts);
        return (pts >= 32'd8) && (pts <= max_pts) && ((pts & (pts - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/ifft_tx_fifo.sv
// Synchronous FIFO with full/empty flags and a clear input; storage is not reset.
module ifft_tx_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/ifft_frame_tx.sv
// Frames a valid/ready sample stream into sop/eop packets for the IFFT sink port.
// Optional IFFT_FRAME_TX_FLUSH_EN adds a flush input that zero-fills the current frame.
module ifft_frame_tx
    import ifft_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned PTS_W      = DEF_PTS_W,
    parameter int unsigned MAX_PTS    = 1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef IFFT_FRAME_TX_FLUSH_EN
    input  logic              flush,
`endif
    input  logic [PTS_W-1:0]  cfg_fftpts,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop,
    output logic [1:0]        src_error,
    output logic [DATA_W-1:0] src_real,
    output logic [DATA_W-1:0] src_imag,
    output logic [PTS_W-1:0]  src_fftpts,
    output logic              busy
);
    tx_state_e         state_q, state_d;
    logic [PTS_W-1:0]  cnt_q, cnt_d, len_q, len_d, len_cur;
    logic              cfg_err_q, cfg_err_d;
    logic              valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [1:0]        error_q, error_d;
    logic [DATA_W-1:0] real_q, real_d, imag_q, imag_d;

    logic              fifo_full, fifo_empty, fifo_pop, fifo_clr;
    logic [2*DATA_W-1:0] fifo_rdata;
    logic              flush_act, have_beat, cfg_ok, load_beat, eop_now;

`ifdef IFFT_FRAME_TX_FLUSH_EN
    logic flushing_q, flushing_d, flush_start;

    // Only a frame whose eop beat has not yet been loaded can be flushed.
    assign flush_start = flush && (state_q == STREAM) && !flushing_q && (cnt_q != '0);
    assign flush_act   = flushing_q || flush_start;
    assign fifo_clr    = flush_start;
    assign in_ready    = !fifo_full && !flushing_q;

    always_comb begin
        flushing_d = flush_act && !(load_beat && eop_now);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) flushing_q <= 1'b0;
        else       flushing_q <= flushing_d;
    end
`else
    assign flush_act = 1'b0;
    assign fifo_clr  = 1'b0;
    assign in_ready  = !fifo_full;
`endif

    ifft_tx_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (fifo_clr),
        .push  (in_valid && in_ready),
        .wdata ({in_real, in_imag}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign have_beat = flush_act || !fifo_empty;
    assign cfg_ok    = is_legal_pts(32'(cfg_fftpts), MAX_PTS);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        len_cur   = len_q;
        cfg_err_d = cfg_err_q;
        valid_d   = valid_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        error_d   = error_q;
        real_d    = real_q;
        imag_d    = imag_q;
        fifo_pop  = 1'b0;
        load_beat = 1'b0;
        eop_now   = 1'b0;

        if (valid_q && src_ready && eop_q) state_d = IDLE;

        // Output register refills when empty or when its beat is leaving.
        if (!valid_q || src_ready) begin
            valid_d = have_beat;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            if (have_beat) begin
                load_beat        = 1'b1;
                fifo_pop         = !flush_act;
                {real_d, imag_d} = flush_act ? '0 : fifo_rdata;
                error_d          = ERR_NONE;
                if (cnt_q == '0) begin
                    len_cur   = cfg_ok ? cfg_fftpts : PTS_W'(MAX_PTS);
                    len_d     = len_cur;
                    sop_d     = 1'b1;
                    state_d   = STREAM;
                    cfg_err_d = cfg_err_q || !cfg_ok;
                end
                eop_now = (cnt_q == len_cur - PTS_W'(1));
                eop_d   = eop_now;
                cnt_d   = eop_now ? '0 : cnt_q + PTS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            cfg_err_q <= 1'b0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            error_q   <= ERR_NONE;
            real_q    <= '0;
            imag_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            cfg_err_q <= cfg_err_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            error_q   <= error_d;
            real_q    <= real_d;
            imag_q    <= imag_d;
        end
    end

    assign src_valid  = valid_q;
    assign src_sop    = sop_q;
    assign src_eop    = eop_q;
    assign src_error  = error_q;
    assign src_real   = real_q;
    assign src_imag   = imag_q;
    assign src_fftpts = len_q;
    assign cfg_err    = cfg_err_q;
    assign busy       = (state_q == STREAM);

endmodule

// File: doc/ifft_frame_tx.md
Name: ifft_frame_tx

Overview:
Frame-forming transmitter that drives the Avalon-ST sink side of the 1024-point IFFT core. It accepts a plain valid/ready stream of complex samples and buffers them. It emits exactly one frame of fftpts points per packet, with sop on the first point and eop on the last, and honours core backpressure. It sits between the spectrum builder and the IFFT sink port.

Parameters:
DATA_W, 32, width of each real/imag component
PTS_W, 11, width of fftpts fields; must cover MAX_PTS
MAX_PTS, 1024, largest legal frame length
FIFO_DEPTH, 4, input buffer depth; power of two, >=2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_fftpts  in  PTS_W  requested frame length; sampled at frame start only
cfg_err  out  1  sticky: an illegal cfg_fftpts was seen
in_valid  in  1  upstream sample valid
in_ready  out  1  upstream may transfer (FIFO not full)
in_real  in  DATA_W  upstream real part
in_imag  in  DATA_W  upstream imaginary part
src_valid  out  1  to core sink_valid
src_ready  in  1  from core sink_ready
src_sop  out  1  to core sink_sop
src_eop  out  1  to core sink_eop
src_error  out  2  to core sink_error
src_real  out  DATA_W  to core sink_real
src_imag  out  DATA_W  to core sink_imag
src_fftpts  out  PTS_W  to core fftpts_in; constant for the whole frame
busy  out  1  a frame is in progress (STREAM state)

Behaviour:
- Reset values: all src_* = 0, busy = 0, cfg_err = 0, in_ready = 1, FIFO empty, state = IDLE, point counter = 0.
- Input transfer occurs when in_valid && in_ready. in_ready = !fifo_full, combinational from FIFO state only. Simultaneous push and pop on a full FIFO is not allowed.
- Output transfer occurs when src_valid && src_ready. Outputs are registered.
- When src_valid=1 and src_ready=0, src_valid, src_real, src_imag, src_sop, src_eop, src_error and src_fftpts hold stable.
- The output register loads from the FIFO when it is empty or when its current beat transfers.
- Latency: a sample accepted at edge N appears on src_* after edge N+1, given an empty pipe and src_ready=1.
- Throughput: one beat per cycle sustained.
- FSM:
  - IDLE -> STREAM when the first beat of a frame is loaded into the output register.
  - On that load: latch frame length L, drive src_sop=1 and busy=1.
  - STREAM -> IDLE when the beat with src_eop=1 transfers.
  - If a next frame's first beat is loaded in the same cycle, the FSM goes directly to STREAM.
- Length check: cfg_fftpts is legal if it is a power of two in [8, MAX_PTS]. An illegal value latches L = MAX_PTS and sets cfg_err; cfg_err clears only on reset. Changes to cfg_fftpts mid-frame are ignored.
- The point counter counts loaded beats 0..L-1. src_eop=1 on count L-1, then the counter wraps to 0.
- src_sop and src_eop are never both 1, since L >= 8.
- src_error is always 2'b00 in the base build.
- src_fftpts = L from the sop beat through the eop beat; it retains L while idle.
- If the FIFO is empty mid-frame, src_valid drops to 0 and the frame resumes when data arrives; no padding is added. Gaps are legal for the core.
- Reset mid-frame: everything clears immediately (asynchronous). The partial frame is discarded and the next beat after reset starts a new sop.

Optional Feature:
Macro: IFFT_FRAME_TX_FLUSH_EN.
- With the macro defined, an extra input port flush (1 bit) is added.
- A flush pulse in STREAM sets the flushing flag.
- While flushing, the block ignores the FIFO and emits zero-valued beats (src_real = src_imag = 0) until the eop beat of the current frame. The flag then clears.
- FIFO contents are discarded at flush assertion, and in_ready=0 while flushing.
- A flush pulse in IDLE is ignored.
- Without the macro, the port is absent and no flushing logic exists.

Decomposition:
- Package ifft_tx_pkg holds:
  - DATA_W and PTS_W defaults
  - state typedef {IDLE, STREAM}
  - error code constants ERR_NONE = 2'b00, ERR_MISSING_SOP = 2'b01, ERR_MISSING_EOP = 2'b10, ERR_UNEXP_EOP = 2'b11
  - function is_legal_pts()
- One sub-module: ifft_tx_fifo, a synchronous FIFO that is FIFO_DEPTH deep and 2*DATA_W wide, with full/empty flags.

Test Plan:
- cfg_fftpts=16, 16 samples with values 1..16, src_ready=1 -> one frame: sop on real=1, eop on real=16, src_fftpts=16, no gaps, busy falls after eop.
- cfg_fftpts=8, src_ready toggling 1/0 every cycle, 24 samples -> 3 frames, no lost or duplicated beats, outputs stable while stalled.
- cfg_fftpts=12 -> L=1024, cfg_err=1; 1024 samples -> eop on the 1024th beat.
- src_ready=0 for 10 cycles -> in_ready drops after 5 accepted beats (FIFO 4 + output register 1); resumes correctly.
- Reset asserted at beat 5 of a 16-point frame -> all outputs zero at once; the next frame starts with sop on its first sample.
- With IFFT_FRAME_TX_FLUSH_EN, cfg_fftpts=16, flush after beat 6 -> beats 7..16 are zero, eop on beat 16, FIFO emptied.
